// File: rtl/reduction_pkg.sv
// Shared types and constants for the fp16 reduction stream.
// Holds the FSM state encoding and the binary16 field constants.
package reduction_pkg;

  localparam int FP16_W = 16;

  localparam logic [FP16_W-1:0] FP16_ZERO    = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]        FP16_EXP_MAX = 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/new_fp16_add.sv
// Combinational IEEE-754 binary16 adder, round-to-nearest-even.
// Handles subnormals, signed zeros, infinities and NaN (canonical quiet NaN out).
module new_fp16_add
  import reduction_pkg::*;
(
  input  logic [FP16_W-1:0] i_a,
  input  logic [FP16_W-1:0] i_b,
  output logic [FP16_W-1:0] o_sum
);

  logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_swap, w_sub;
  logic [15:0] w_big, w_small;
  logic [4:0]  w_big_exp, w_small_exp, w_shift;
  logic [13:0] w_big_man, w_small_man, w_aligned;
  logic [14:0] w_sum;
  logic [13:0] w_norm;
  logic [5:0]  w_exp, w_lshift;
  logic [3:0]  w_lz;
  logic        w_round_up;
  logic [14:0] w_rounded;

  assign w_a_inf = (i_a[14:10] == FP16_EXP_MAX) && (i_a[9:0] == 10'd0);
  assign w_b_inf = (i_b[14:10] == FP16_EXP_MAX) && (i_b[9:0] == 10'd0);
  assign w_a_nan = (i_a[14:10] == FP16_EXP_MAX) && (i_a[9:0] != 10'd0);
  assign w_b_nan = (i_b[14:10] == FP16_EXP_MAX) && (i_b[9:0] != 10'd0);

  // Order by magnitude so the subtraction below never goes negative.
  assign w_swap      = i_b[14:0] > i_a[14:0];
  assign w_big       = w_swap ? i_b : i_a;
  assign w_small     = w_swap ? i_a : i_b;
  assign w_sub       = w_big[15] ^ w_small[15];
  assign w_big_exp   = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
  assign w_small_exp = (w_small[14:10] == 5'd0) ? 5'd1 : w_small[14:10];
  assign w_shift     = w_big_exp - w_small_exp;
  assign w_big_man   = {w_big[14:10] != 5'd0, w_big[9:0], 3'b000};
  assign w_small_man = {w_small[14:10] != 5'd0, w_small[9:0], 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_aligned = '0;
    if (w_shift >= 5'd14) begin
      w_aligned[0] = |w_small_man;
    end else begin
      w_aligned    = w_small_man >> w_shift;
      w_aligned[0] = w_aligned[0] | (|(w_small_man & ((14'd1 << w_shift) - 14'd1)));
    end
  end

  assign w_sum = w_sub ? ({1'b0, w_big_man} - {1'b0, w_aligned})
                       : ({1'b0, w_big_man} + {1'b0, w_aligned});

  // Left normalisation stops at exponent 1 so tiny results become subnormals.
  always_comb begin
    w_lz = 4'd14;
    for (int k = 0; k < 14; k++) begin
      if (w_sum[k]) w_lz = 4'(13 - k);
    end
    w_lshift = '0;
    w_exp    = {1'b0, w_big_exp};
    w_norm   = w_sum[13:0];
    if (w_sum[14]) begin
      w_norm = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_exp  = w_exp + 6'd1;
    end else begin
      w_lshift = ({2'b00, w_lz} < (w_exp - 6'd1)) ? {2'b00, w_lz} : (w_exp - 6'd1);
      w_norm   = 14'(w_sum << w_lshift);
      w_exp    = w_exp - w_lshift;
    end
  end

  assign w_round_up = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
  assign w_rounded  = {(w_norm[13] ? w_exp[4:0] : 5'd0), w_norm[12:3]} + 15'(w_round_up);

  always_comb begin
    o_sum = {w_big[15], w_rounded};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15]))) begin
      o_sum = FP16_QNAN;
    end else if (w_a_inf) begin
      o_sum = i_a;
    end else if (w_b_inf) begin
      o_sum = i_b;
    end else if (w_sum == 15'd0) begin
      o_sum = {i_a[15] & i_b[15], 15'd0};
    end else if (w_exp >= 6'd31) begin
      o_sum = {w_big[15], FP16_EXP_MAX, 10'd0};
    end
  end

endmodule

// File: rtl/reduction_lane.sv
// One lane: pairwise fp16 adder tree over the beat operands, then a final add
// with either the seed (first beat) or the running accumulator.
module reduction_lane
  import reduction_pkg::*;
#(
  parameter int WIDTH         = FP16_W,
  parameter int PARALLEL_SIZE = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_load,
  input  logic                                i_first,
  input  logic [WIDTH-1:0]                    i_seed,
  input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0] i_operands,
  output logic [WIDTH-1:0]                    o_acc
);

  localparam int LEVELS = $clog2(PARALLEL_SIZE);

  logic [WIDTH-1:0] w_lvl [LEVELS+1][PARALLEL_SIZE];
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_acc;

  for (genvar j = 0; j < PARALLEL_SIZE; j++) begin : g_leaf
    assign w_lvl[0][j] = i_operands[j];
  end

  // Adjacent pairs combine in ascending order; an odd tail passes up unchanged.
  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int N_IN  = (PARALLEL_SIZE + (1 << l) - 1) >> l;
    localparam int N_OUT = (N_IN + 1) / 2;
    for (genvar j = 0; j < N_IN / 2; j++) begin : g_pair
      new_fp16_add u_add (
        .i_a   (w_lvl[l][2*j]),
        .i_b   (w_lvl[l][2*j+1]),
        .o_sum (w_lvl[l+1][j])
      );
    end
    if (N_IN % 2 == 1) begin : g_odd
      assign w_lvl[l+1][N_OUT-1] = w_lvl[l][N_IN-1];
    end
    for (genvar j = N_OUT; j < PARALLEL_SIZE; j++) begin : g_pad
      assign w_lvl[l+1][j] = FP16_ZERO;
    end
  end

  assign w_base = i_first ? i_seed : r_acc;

  new_fp16_add u_acc_add (
    .i_a   (w_base),
    .i_b   (w_lvl[LEVELS][0]),
    .o_sum (w_next)
  );

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= FP16_ZERO;
    end else if (i_load) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/reduction_stream.sv
// Streaming per-lane fp16 reduction: accepts one operand beat per clock,
// accumulates across a first..last burst and presents the sums with a handshake.
module reduction_stream
  import reduction_pkg::*;
#(
  parameter int WIDTH         = FP16_W,
  parameter int TILE_SIZE     = 129,
  parameter int PARALLEL_SIZE = 3,
  parameter int CNT_W         = 16
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic                                               in_first,
  input  logic                                               in_last,
  input  logic [TILE_SIZE-1:0][WIDTH-1:0]                    init_i,
  input  logic [PARALLEL_SIZE-1:0][TILE_SIZE-1:0][WIDTH-1:0] operand_i,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [TILE_SIZE-1:0][WIDTH-1:0]                    reduction_o,
  output logic [CNT_W-1:0]                                   beat_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             w_accept;
  logic             w_take_first;
  logic             w_take_next;
  logic             w_load;

  assign w_accept     = in_valid && r_in_ready;
  assign w_take_first = w_accept && in_first;
  assign w_take_next  = w_accept && !in_first && (r_state == ACCUM);
  assign w_load       = w_take_first || w_take_next;

  // A first beat always restarts, discarding any partial sum still in ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_load) begin
            if (w_take_first)          r_count <= CNT_W'(1);
            else if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
            if (in_last) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar t = 0; t < TILE_SIZE; t++) begin : g_lane
    logic [PARALLEL_SIZE-1:0][WIDTH-1:0] w_ops;
    for (genvar p = 0; p < PARALLEL_SIZE; p++) begin : g_op
      assign w_ops[p] = operand_i[p][t];
    end
    reduction_lane #(
      .WIDTH         (WIDTH),
      .PARALLEL_SIZE (PARALLEL_SIZE)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_first    (in_first),
      .i_seed     (init_i[t]),
      .i_operands (w_ops),
      .o_acc      (reduction_o[t])
    );
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign beat_count_o = r_count;

endmodule

// File: doc/reduction_stream.md
REDUCTION_STREAM -- requirements
Module: reduction_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element width (fp16 encoding).
REQ-002 SHALL have parameter TILE_SIZE, default 129, number of independent lanes.
REQ-003 SHALL have parameter PARALLEL_SIZE, default 3, operands per lane per beat, range 1..8.
REQ-004 SHALL have parameter CNT_W, default 16, beat-counter width.
REQ-005 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, operand beat valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts beat.
REQ-009 SHALL have port in_first, input, 1, beat opens a new reduction.
REQ-010 SHALL have port in_last, input, 1, beat closes the reduction.
REQ-011 SHALL have port init_i, input, TILE_SIZE x WIDTH, per-lane seed added on a first beat.
REQ-012 SHALL have port operand_i, input, PARALLEL_SIZE x TILE_SIZE x WIDTH, beat operands.
REQ-013 SHALL have port out_valid, output, 1, result available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port reduction_o, output, TILE_SIZE x WIDTH, per-lane accumulated sum.
REQ-016 SHALL have port beat_count_o, output, CNT_W, beats accumulated into reduction_o.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-018 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in DONE; beat accepted when in_valid&&in_ready.
REQ-019 SHALL in IDLE ignore accepted beats with in_first=0 (dropped, no state change).
REQ-020 SHALL on accepted in_first beat (IDLE or ACCUM) load acc[i] <= init_i[i] + tree(operand_i[*][i]), count <= 1; any partial reduction in ACCUM is discarded.
REQ-021 SHALL on accepted non-first beat in ACCUM load acc[i] <= acc[i] + tree(operand_i[*][i]), count <= count+1, count saturating at 2^CNT_W-1.
REQ-022 SHALL compute tree() as pairwise fp16 adds by ascending operand index, level by level, odd element passed through; the final add is (accumulator-or-seed, tree result); order fixed for bit-exact modelling.
REQ-023 SHALL be single-cycle: one beat per clock sustained in ACCUM, acc updated on the accepting edge.
REQ-024 SHALL transition IDLE->ACCUM on accepted first beat with in_last=0; ->DONE on accepted beat with in_last=1 (first&&last gives a one-beat reduction).
REQ-025 SHALL in DONE assert out_valid, hold reduction_o and beat_count_o stable until out_valid&&out_ready, then go to IDLE.
REQ-026 SHALL drive reduction_o=acc and beat_count_o=count in all states; values valid only with out_valid.

Reset
REQ-027 SHALL on rst (any state, including mid-reduction or DONE) set state=IDLE, acc=0, count=0, out_valid=0, in_ready=1 on the next edge.
REQ-028 SHALL give rst priority over a simultaneous accepted beat or output handshake.

Structure
REQ-029 SHALL place WIDTH default, FSM state enum and fp16 constants (zero 0x0000) in shared package reduction_pkg.
REQ-030 SHALL instantiate the existing combinational new_fp16_add for every add; one natural sub-module reduction_lane (tree plus accumulate for one lane), generated TILE_SIZE times.

Verification
REQ-031 SHALL cover: PAR=3, init=0, one first+last beat of all 0x3C00 -> out_valid next cycle, reduction_o all 0x4200, beat_count_o=1.
REQ-032 SHALL cover: two beats of all 0x3C00 (first, then last) -> reduction_o 0x4600, count=2, in_ready low while DONE.
REQ-033 SHALL cover: init_i=0x3800, one first+last beat of 0x3C00 -> reduction_o 0x4300 (3.5).
REQ-034 SHALL cover: out_ready=0 for 5 cycles in DONE -> outputs stable, in_valid beats not accepted; out_ready=1 -> IDLE.
REQ-035 SHALL cover: new in_first beat mid-ACCUM -> prior partial discarded, count=1; rst mid-ACCUM -> acc=0, IDLE, out_valid=0.
REQ-036 SHALL cover: non-first beat in IDLE -> ignored, state remains IDLE, acc unchanged.
